butterfly_feeder: RTL and testbench
===================================

Name: butterfly_feeder

Overview:
Upstream stage of the radix-2 butterfly for one decimation-in-time FFT stage.
- Buffers one frame of N complex samples arriving in natural order.
- Then issues the N/2 operand pairs (XA, XB) with the matching twiddle W, one pair every two cycles, honouring the butterfly's no-back-to-back x_nd rule.
- Forwards the XA address on m so the downstream collector can place YA/YB (YB address = XA address + 2^STAGE).

Parameters:
N, 8, frame length; power of two, >= 4
LOG_N, 3, log2(N)
X_WDTH, 16, width of each real/imag part
STAGE, 0, FFT stage index, 0..LOG_N-1; butterfly span = 2^STAGE
M_WDTH, LOG_N, width of m; carries the XA address

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
in_data  in  2*X_WDTH  sample {re, im}, signed
in_nd  in  1  in_data valid
in_rdy  out  1  feeder accepts in_data this cycle
xa  out  2*X_WDTH  XA operand {re, im}
xb  out  2*X_WDTH  XB operand {re, im}
w  out  2*X_WDTH  twiddle {re, im}
m  out  M_WDTH  XA address
x_nd  out  1  operands valid; single-cycle pulse

Behaviour:
- States: FILL, ISSUE.
- Reset values: state FILL, fill count 0, pair counter k 0, gap flag 0, x_nd 0. xa, xb, w, m are 0 and hold their last value when x_nd=0.
- in_rdy is 1 exactly when state is FILL (combinational from state).
- FILL:
  - An edge with in_nd=1 writes in_data to buffer[count] and increments count.
  - On the Nth accept, count wraps to 0 and state becomes ISSUE at that edge.
  - in_nd while in_rdy=0 is ignored; the buffer is unchanged.
- ISSUE pairing for pair k = 0..N/2-1:
  - pos = k mod 2^STAGE; grp = k >> STAGE.
  - ia = grp*2^(STAGE+1) + pos; ib = ia + 2^STAGE.
  - Twiddle index j = pos << (LOG_N-1-STAGE).
- ISSUE timing:
  - All outputs are registered.
  - At the first edge after entering ISSUE, drive x_nd=1 with xa=buffer[ia], xb=buffer[ib], w=W^j, m=ia for k=0.
  - At the next edge drive x_nd=0 (gap).
  - Repeat, so x_nd pulses on alternate cycles, N/2 pulses in all.
  - The edge that registers pair k=N/2-1 also sets state to FILL and k to 0. in_rdy rises in the same cycle that x_nd is high for the last pair.
- Latency: first x_nd is 1 cycle after the Nth sample is accepted. The frame occupies N cycles of ISSUE, i.e. 2 edges per pair.
- Twiddle format: W^j = exp(-2πi·j/N), with 1.0 = 2^(X_WDTH-2), matching the multiply block's fixed point.
  - re = round(cos(2πj/N)·2^(X_WDTH-2))
  - im = round(-sin(2πj/N)·2^(X_WDTH-2))
  - Range j = 0..N/2-1.
- Buffer overwrite: the next frame may overwrite buffer entries as soon as FILL resumes, because the operands are already registered.
- Reset mid-operation: reset in FILL or ISSUE discards the partial frame and any unissued pairs. x_nd=0 from the reset edge; the next frame starts at address 0.
- No width growth: data passes through unmodified. Scaling is the butterfly's job.

Decomposition:
- Shared header fft_defs: twiddle fixed-point scale (X_WDTH-2) and the state encodings FILL/ISSUE.
- Sub-module twiddle_rom (params N, LOG_N, X_WDTH): combinational j -> W^j, generated from the formula above at elaboration. It is reused by later stages.

Test Plan:
1. N=8, STAGE=0, samples i -> {re=i, im=-i} for i=0..7 -> 4 x_nd pulses 2 cycles apart. (ia,ib) = (0,1),(2,3),(4,5),(6,7); w=(16384,0) on all; m = 0,2,4,6; first pulse 1 cycle after the 8th accept.
2. N=8, STAGE=2, same frame -> pairs (0,4),(1,5),(2,6),(3,7). w = (16384,0), (11585,-11585), (0,-16384), (-11585,-11585).
3. N=8, STAGE=1 -> pairs (0,2),(1,3),(4,6),(5,7). w = W^0, W^2, W^0, W^2; m = 0,1,4,5.
4. in_nd held high through ISSUE with value 0x7FFF7FFF -> those samples are ignored; in_rdy=0 during ISSUE. The next frame's first accepted sample lands at address 0 in the same cycle as the last x_nd.
5. Reset asserted after 5 samples, then after the 2nd x_nd pulse of a later frame -> x_nd=0 from the reset edge, in_rdy=1. A fresh 8-sample frame then produces correct pairs starting at k=0.
6. Back-to-back frames with in_nd continuously high -> x_nd never high on two consecutive cycles; each frame produces exactly N/2 pulses.

Source files
------------

// File: rtl/butterfly_feeder_pkg.sv
// Shared FFT definitions: twiddle fixed-point scale and the feeder's state encodings.
package butterfly_feeder_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } feeder_state_e;

  localparam real TW_PI = 3.14159265358979323846;

  // Twiddles carry 1.0 as 2^(X_WDTH-2) so the multiplier can keep its product headroom.
  function automatic int tw_frac_bits(input int x_wdth);
    return x_wdth - 2;
  endfunction

endpackage

// File: rtl/butterfly_feeder_if.sv
// Sample input stream and butterfly operand output bundle of the feeder.
interface butterfly_feeder_if #(
  parameter int X_WDTH = 16,
  parameter int M_WDTH = 3
);
  logic [2*X_WDTH-1:0] in_data;
  logic                in_nd;
  logic                in_rdy;
  logic [2*X_WDTH-1:0] xa;
  logic [2*X_WDTH-1:0] xb;
  logic [2*X_WDTH-1:0] w;
  logic [M_WDTH-1:0]   m;
  logic                x_nd;

  modport master (output in_data, in_nd, input in_rdy, xa, xb, w, m, x_nd);
  modport slave  (input in_data, in_nd, output in_rdy, xa, xb, w, m, x_nd);
endinterface

// File: rtl/butterfly_feeder_twiddle_rom.sv
// Combinational twiddle table j -> W^j = exp(-2*pi*i*j/N), built at elaboration time.
module twiddle_rom
  import butterfly_feeder_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOG_N  = 3,
  parameter int X_WDTH = 16
) (
  input  logic [LOG_N-2:0]    j,
  output logic [2*X_WDTH-1:0] w
);

  localparam real SCALE = real'(1 << tw_frac_bits(X_WDTH));

  logic [2*X_WDTH-1:0] rom [N/2];

  // int' of a real rounds to nearest, which is the rounding the table wants.
  for (genvar g = 0; g < N/2; g++) begin : g_rom
    localparam real ANG = 2.0 * TW_PI * real'(g) / real'(N);
    localparam int  RE  = int'($cos(ANG) * SCALE);
    localparam int  IM  = int'(-$sin(ANG) * SCALE);
    assign rom[g] = {RE[X_WDTH-1:0], IM[X_WDTH-1:0]};
  end

  assign w = rom[j];

endmodule

// File: rtl/butterfly_feeder.sv
// Radix-2 DIT stage feeder: buffers one natural-order frame, then issues
// (XA, XB, W) operand pairs every other cycle with the XA address on m.
module butterfly_feeder
  import butterfly_feeder_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOG_N  = 3,
  parameter int X_WDTH = 16,
  parameter int STAGE  = 0,
  parameter int M_WDTH = LOG_N
) (
  input logic               clk,
  input logic               rst_n,
  butterfly_feeder_if.slave bus
);

  localparam int DW = 2 * X_WDTH;
  localparam int KW = LOG_N - 1;
  localparam logic [LOG_N-1:0] SPAN     = LOG_N'(1 << STAGE);
  localparam logic [KW-1:0]    POS_MASK = KW'((1 << STAGE) - 1);
  localparam logic [LOG_N-1:0] LAST_CNT = LOG_N'(N - 1);
  localparam logic [KW-1:0]    LAST_K   = KW'(N/2 - 1);

  feeder_state_e     state_q, state_d;
  logic [LOG_N-1:0]  count_q, count_d;
  logic [KW-1:0]     k_q, k_d;
  logic              gap_q, gap_d;
  logic              x_nd_q, x_nd_d;
  logic [DW-1:0]     xa_q, xa_d, xb_q, xb_d, w_q, w_d;
  logic [M_WDTH-1:0] m_q, m_d;
  logic [DW-1:0]     mem_q [N];
  logic              wr_en;
  logic [LOG_N-1:0]  k_ext, ia, ib;
  logic [KW-1:0]     pos, j;
  logic [DW-1:0]     w_rom;

  // pos never exceeds 2^STAGE-1, so it and the twiddle index fit in KW bits.
  always_comb begin
    k_ext = {1'b0, k_q};
    pos   = k_q & POS_MASK;
    ia    = ((k_ext >> STAGE) << (STAGE + 1)) | {1'b0, pos};
    ib    = ia | SPAN;
    j     = pos << (KW - STAGE);
  end

  twiddle_rom #(
    .N      (N),
    .LOG_N  (LOG_N),
    .X_WDTH (X_WDTH)
  ) u_twiddle_rom (
    .j (j),
    .w (w_rom)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    k_d     = k_q;
    gap_d   = gap_q;
    x_nd_d  = 1'b0;
    xa_d    = xa_q;
    xb_d    = xb_q;
    w_d     = w_q;
    m_d     = m_q;
    wr_en   = 1'b0;
    case (state_q)
      FILL: begin
        if (bus.in_nd) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LAST_CNT) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!gap_q) begin
          x_nd_d = 1'b1;
          xa_d   = mem_q[ia];
          xb_d   = mem_q[ib];
          w_d    = w_rom;
          m_d    = M_WDTH'(ia);
          gap_d  = 1'b1;
          k_d    = k_q + 1'b1;
          if (k_q == LAST_K) begin
            state_d = FILL;
            gap_d   = 1'b0;
          end
        end else begin
          gap_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= '0;
      k_q     <= '0;
      gap_q   <= 1'b0;
      x_nd_q  <= 1'b0;
      xa_q    <= '0;
      xb_q    <= '0;
      w_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      x_nd_q  <= x_nd_d;
      xa_q    <= xa_d;
      xb_q    <= xb_d;
      w_q     <= w_d;
      m_q     <= m_d;
    end
  end

  // The frame buffer needs no reset: a new frame always refills it from address 0.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) mem_q[count_q] <= bus.in_data;
  end

  assign bus.in_rdy = (state_q == FILL);
  assign bus.x_nd   = x_nd_q;
  assign bus.xa     = xa_q;
  assign bus.xb     = xb_q;
  assign bus.w      = w_q;
  assign bus.m      = m_q;

endmodule

// File: tb/tb_butterfly_feeder.sv
// Self-checking bench: three feeders (STAGE 0, 1, 2) share one input stream and are
// compared every cycle against a frame-level reference model plus a fixed pair table.
module tb_butterfly_feeder;

  localparam int N      = 8;
  localparam int LOG_N  = 3;
  localparam int X_WDTH = 16;
  localparam int DW     = 2 * X_WDTH;
  localparam int NS     = 3;

  typedef struct {
    int stage;
    int k;
    int ia;
    int ib;
    int w_re;
    int w_im;
    int m;
  } pair_vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_nd;
  logic [DW-1:0] in_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  butterfly_feeder_if #(.X_WDTH(X_WDTH), .M_WDTH(LOG_N)) bus0 ();
  butterfly_feeder_if #(.X_WDTH(X_WDTH), .M_WDTH(LOG_N)) bus1 ();
  butterfly_feeder_if #(.X_WDTH(X_WDTH), .M_WDTH(LOG_N)) bus2 ();

  assign bus0.in_nd = in_nd;  assign bus0.in_data = in_data;
  assign bus1.in_nd = in_nd;  assign bus1.in_data = in_data;
  assign bus2.in_nd = in_nd;  assign bus2.in_data = in_data;

  butterfly_feeder #(.N(N), .LOG_N(LOG_N), .X_WDTH(X_WDTH), .STAGE(0), .M_WDTH(LOG_N))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  butterfly_feeder #(.N(N), .LOG_N(LOG_N), .X_WDTH(X_WDTH), .STAGE(1), .M_WDTH(LOG_N))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  butterfly_feeder #(.N(N), .LOG_N(LOG_N), .X_WDTH(X_WDTH), .STAGE(2), .M_WDTH(LOG_N))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  logic             rdy_o  [NS];
  logic             xnd_o  [NS];
  logic [DW-1:0]    xa_o   [NS];
  logic [DW-1:0]    xb_o   [NS];
  logic [DW-1:0]    w_o    [NS];
  logic [LOG_N-1:0] m_o    [NS];

  assign rdy_o[0] = bus0.in_rdy; assign xnd_o[0] = bus0.x_nd; assign xa_o[0] = bus0.xa;
  assign xb_o[0]  = bus0.xb;     assign w_o[0]   = bus0.w;    assign m_o[0]  = bus0.m;
  assign rdy_o[1] = bus1.in_rdy; assign xnd_o[1] = bus1.x_nd; assign xa_o[1] = bus1.xa;
  assign xb_o[1]  = bus1.xb;     assign w_o[1]   = bus1.w;    assign m_o[1]  = bus1.m;
  assign rdy_o[2] = bus2.in_rdy; assign xnd_o[2] = bus2.x_nd; assign xa_o[2] = bus2.xa;
  assign xb_o[2]  = bus2.xb;     assign w_o[2]   = bus2.w;    assign m_o[2]  = bus2.m;

  // Reference model: frame-level view of accept / issue timeline.
  bit               m_fill;
  int               m_cnt;
  int               m_t;
  logic [DW-1:0]    m_frame [N];
  logic [DW-1:0]    m_snap  [N];
  logic             e_xnd;
  logic [DW-1:0]    e_xa [NS];
  logic [DW-1:0]    e_xb [NS];
  logic [DW-1:0]    e_w  [NS];
  logic [LOG_N-1:0] e_m  [NS];

  logic          prev_xnd [NS];
  int            pulses   [NS];
  int            obs_n    [NS];
  logic [DW-1:0] obs_xa   [NS][N/2];
  logic [DW-1:0] obs_xb   [NS][N/2];
  logic [DW-1:0] obs_w    [NS][N/2];
  int            obs_m    [NS][N/2];

  function automatic logic [DW-1:0] smp(input int i);
    logic [15:0] re, im;
    re = 16'(i);
    im = 16'(-i);
    return {re, im};
  endfunction

  function automatic logic [DW-1:0] ref_tw(input int jj);
    real a;
    int  re, im;
    logic [15:0] r16, i16;
    a   = 2.0 * 3.141592653589793 * real'(jj) / real'(N);
    re  = int'($cos(a) * real'(1 << (X_WDTH - 2)));
    im  = int'(-$sin(a) * real'(1 << (X_WDTH - 2)));
    r16 = 16'(re);
    i16 = 16'(im);
    return {r16, i16};
  endfunction

  task automatic ref_pair(input int stage, input int k, output int ia, output int ib, output int jj);
    int span;
    span = 1 << stage;
    ia   = (k / span) * 2 * span + (k % span);
    ib   = ia + span;
    jj   = (k % span) * (N / (2 * span));
  endtask

  task automatic model_edge(input logic rst_v, input logic nd_v, input logic [DW-1:0] d_v);
    int ia, ib, jj, k;
    if (!rst_v) begin
      m_fill = 1'b1; m_cnt = 0; m_t = 0; e_xnd = 1'b0;
      for (int s = 0; s < NS; s++) begin
        e_xa[s] = '0; e_xb[s] = '0; e_w[s] = '0; e_m[s] = '0;
      end
    end else if (m_fill) begin
      e_xnd = 1'b0;
      if (nd_v) begin
        m_frame[m_cnt] = d_v;
        m_cnt++;
        if (m_cnt == N) begin
          m_fill = 1'b0; m_cnt = 0; m_t = 0;
          m_snap = m_frame;
        end
      end
    end else begin
      if (m_t % 2 == 0) begin
        k = m_t / 2;
        e_xnd = 1'b1;
        for (int s = 0; s < NS; s++) begin
          ref_pair(s, k, ia, ib, jj);
          e_xa[s] = m_snap[ia];
          e_xb[s] = m_snap[ib];
          e_w[s]  = ref_tw(jj);
          e_m[s]  = LOG_N'(ia);
        end
        if (k == N/2 - 1) m_fill = 1'b1;
      end else begin
        e_xnd = 1'b0;
      end
      m_t++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    for (int s = 0; s < NS; s++) begin
      checkOutput($sformatf("s%0d_in_rdy", s), 64'(rdy_o[s]), 64'(m_fill));
      checkOutput($sformatf("s%0d_x_nd", s), 64'(xnd_o[s]), 64'(e_xnd));
      checkOutput($sformatf("s%0d_xa", s), 64'(xa_o[s]), 64'(e_xa[s]));
      checkOutput($sformatf("s%0d_xb", s), 64'(xb_o[s]), 64'(e_xb[s]));
      checkOutput($sformatf("s%0d_w", s), 64'(w_o[s]), 64'(e_w[s]));
      checkOutput($sformatf("s%0d_m", s), 64'(m_o[s]), 64'(e_m[s]));
      checkOutput($sformatf("s%0d_no_b2b", s), 64'(xnd_o[s] & prev_xnd[s]), 64'd0);
      if (xnd_o[s] === 1'b1) begin
        pulses[s]++;
        if (obs_n[s] < N/2) begin
          obs_xa[s][obs_n[s]] = xa_o[s];
          obs_xb[s][obs_n[s]] = xb_o[s];
          obs_w[s][obs_n[s]]  = w_o[s];
          obs_m[s][obs_n[s]]  = int'(m_o[s]);
          obs_n[s]++;
        end
      end
      prev_xnd[s] = xnd_o[s];
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic nd_v, input logic [DW-1:0] d_v);
    rst_n   = rst_v;
    in_nd   = nd_v;
    in_data = d_v;
    @(posedge clk);
    model_edge(rst_v, nd_v, d_v);
    #1;
    checkAll();
  endtask

  task automatic clear_obs();
    for (int s = 0; s < NS; s++) begin
      obs_n[s]  = 0;
      pulses[s] = 0;
    end
  endtask

  pair_vec_t vecs [12];

  initial begin
    vecs[0]  = '{0, 0, 0, 1, 16384, 0, 0};
    vecs[1]  = '{0, 1, 2, 3, 16384, 0, 2};
    vecs[2]  = '{0, 2, 4, 5, 16384, 0, 4};
    vecs[3]  = '{0, 3, 6, 7, 16384, 0, 6};
    vecs[4]  = '{2, 0, 0, 4, 16384, 0, 0};
    vecs[5]  = '{2, 1, 1, 5, 11585, -11585, 1};
    vecs[6]  = '{2, 2, 2, 6, 0, -16384, 2};
    vecs[7]  = '{2, 3, 3, 7, -11585, -11585, 3};
    vecs[8]  = '{1, 0, 0, 2, 16384, 0, 0};
    vecs[9]  = '{1, 1, 1, 3, 0, -16384, 1};
    vecs[10] = '{1, 2, 4, 6, 16384, 0, 4};
    vecs[11] = '{1, 3, 5, 7, 0, -16384, 5};

    for (int s = 0; s < NS; s++) prev_xnd[s] = 1'b0;
    clear_obs();
    rst_n = 1'b0; in_nd = 1'b0; in_data = '0;

    // Reset state.
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);

    // Ramp frame {i, -i} through all three stages, then check against the pair table.
    clear_obs();
    for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, smp(i));
    checkOutput("pre_first_pulse", 64'(xnd_o[0]), 64'd0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("first_pulse_latency", 64'(xnd_o[0]), 64'd1);
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b0, '0);
    for (int s = 0; s < NS; s++)
      checkOutput($sformatf("s%0d_pulse_count", s), 64'(pulses[s]), 64'(N/2));
    for (int v = 0; v < 12; v++) begin
      logic [15:0] wr, wi;
      wr = 16'(vecs[v].w_re);
      wi = 16'(vecs[v].w_im);
      checkOutput($sformatf("tbl%0d_xa", v), 64'(obs_xa[vecs[v].stage][vecs[v].k]), 64'(smp(vecs[v].ia)));
      checkOutput($sformatf("tbl%0d_xb", v), 64'(obs_xb[vecs[v].stage][vecs[v].k]), 64'(smp(vecs[v].ib)));
      checkOutput($sformatf("tbl%0d_w", v), 64'(obs_w[vecs[v].stage][vecs[v].k]), 64'({wr, wi}));
      checkOutput($sformatf("tbl%0d_m", v), 64'(obs_m[vecs[v].stage][vecs[v].k]), 64'(vecs[v].m));
    end

    // in_nd held high through ISSUE: ignored until in_rdy returns with the last pulse.
    for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, $urandom);
    for (int c = 0; c < 7; c++) applyStimulus(1'b1, 1'b1, 32'h7FFF7FFF);
    checkOutput("last_pulse_rdy", 64'({rdy_o[0], xnd_o[0]}), 64'(2'b11));
    clear_obs();
    applyStimulus(1'b1, 1'b1, 32'h7FFF7FFF);
    for (int i = 1; i < N; i++) applyStimulus(1'b1, 1'b1, $urandom);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("addr0_after_issue", 64'(obs_xa[0][0]), 64'(32'h7FFF7FFF));
    for (int c = 0; c < 8; c++) applyStimulus(1'b1, 1'b0, '0);

    // Reset mid-fill, then mid-issue, then a clean frame.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, $urandom);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("rst_fill_rdy", 64'(rdy_o[1]), 64'd1);
    for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, $urandom);
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("rst_issue_xnd_rdy", 64'({xnd_o[2], rdy_o[2]}), 64'(2'b01));
    clear_obs();
    for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, $urandom);
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("post_rst_pulses", 64'(pulses[1]), 64'(N/2));

    // Back-to-back frames with in_nd continuously high: three frames, N/2 pulses each.
    clear_obs();
    for (int c = 0; c < 45; c++) applyStimulus(1'b1, 1'b1, $urandom);
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b0, '0);
    for (int s = 0; s < NS; s++)
      checkOutput($sformatf("s%0d_b2b_pulses", s), 64'(pulses[s]), 64'(3 * N/2));

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++)
      applyStimulus(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 3) != 0), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
